// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown controller and its DEC partner.
package countdown_pkg;

   localparam int unsigned DataWidthDefault = 8;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Upstream handshake of countdown_ctrl: request side (master) and controller side (slave).
interface countdown_ctrl_if
   import countdown_pkg::*;
#(
   parameter int unsigned DataWidth = DataWidthDefault
) ();

   logic                 load;
   logic [DataWidth-1:0] load_val;
   logic                 hold;
   logic                 clear;
   logic                 ready;
   logic                 busy;
   logic                 done;

   modport master (
      output load, load_val, hold, clear,
      input  ready, busy, done
   );

   modport slave (
      input  load, load_val, hold, clear,
      output ready, busy, done
   );

endinterface

// File: rtl/countdown_dec.sv
// Combinational DEC decrementer: d = a - 1 modulo 2^DataWidth.
module countdown_dec
   import countdown_pkg::*;
#(
   parameter int unsigned DataWidth = DataWidthDefault
) (
   input  logic [DataWidth-1:0] a,
   output logic [DataWidth-1:0] d
);

   assign d = a - DataWidth'(1);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown register + IDLE/RUN/DONE FSM feeding an external DEC instance.
// Optional periodic mode when COUNTDOWN_AUTORELOAD_EN is defined.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int unsigned DataWidth = DataWidthDefault
) (
   input  logic                 clk,
   input  logic                 rst_n,
   countdown_ctrl_if.slave      bus,
   input  logic [DataWidth-1:0] dec_d,
   output logic [DataWidth-1:0] dec_a
);

   state_e               state_q;
   logic [DataWidth-1:0] count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [DataWidth-1:0] reload_q;
`endif

   // Count arithmetic is delegated to DEC; this block only selects what to capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else if (bus.clear) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.load) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                  reload_q <= bus.load_val;
`endif
                  count_q <= bus.load_val;
                  state_q <= (bus.load_val == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (!bus.hold) begin
                  // Never step past zero, even if RUN were entered with a zero count.
                  if (count_q <= DataWidth'(1)) begin
                     count_q <= '0;
                     state_q <= StDone;
                  end else begin
                     count_q <= dec_d;
                  end
               end
            end
            StDone: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
               if (reload_q != '0) begin
                  count_q <= reload_q;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
`else
               state_q <= StIdle;
`endif
            end
            default: begin
               state_q <= StIdle;
               count_q <= '0;
            end
         endcase
      end
   end

   assign dec_a     = count_q;
   assign bus.ready = (state_q == StIdle);
   assign bus.busy  = (state_q == StRun) || (state_q == StDone);
   assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl + countdown_dec; Done timing checked by a scoreboard.
module tb_countdown_ctrl;
   import countdown_pkg::*;

   localparam int unsigned Dw = DataWidthDefault;

   logic          clk;
   logic          rst_n;
   logic [Dw-1:0] dec_a;
   logic [Dw-1:0] dec_d;

   countdown_ctrl_if #(.DataWidth(Dw)) bus ();

   countdown_ctrl #(.DataWidth(Dw)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .dec_d (dec_d),
      .dec_a (dec_a)
   );

   countdown_dec #(.DataWidth(Dw)) dec (
      .a (dec_a),
      .d (dec_d)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: every Done pulse must match the oldest expected completion edge.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            check("done_edge", cyc, exp_q.pop_front());
            check("done_dec_a", int'(dec_a), 0);
            check("done_ready", int'(bus.ready), 0);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.hold     = 1'b0;
      bus.clear    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dec_a", int'(dec_a), 0);
      check("rst_ready", int'(bus.ready), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      rst_n = 1'b1;
      ticks(3);
      check("idle_ready", int'(bus.ready), 1);
      check("idle_dec_a", int'(dec_a), 0);

      // N=10 with full count trace
      bus.load = 1'b1; bus.load_val = 8'd10;
      exp_q.push_back(cyc + 1 + 10);
      tick();
      bus.load = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         check("n10_dec_a", int'(dec_a), 10 - k);
         check("n10_busy", int'(bus.busy), 1);
         tick();
      end
      check("n10_ready", int'(bus.ready), 1);

      // N=0
      bus.load = 1'b1; bus.load_val = 8'd0;
      exp_q.push_back(cyc + 1);
      tick();
      bus.load = 1'b0;
      check("n0_ready_in_done", int'(bus.ready), 0);
      tick();
      check("n0_ready", int'(bus.ready), 1);

      // N=255
      bus.load = 1'b1; bus.load_val = 8'd255;
      exp_q.push_back(cyc + 1 + 255);
      tick();
      bus.load = 1'b0;
      tick();
      check("n255_dec_a_e1", int'(dec_a), 254);
      ticks(254);
      check("n255_dec_a_e255", int'(dec_a), 0);
      tick();
      check("n255_ready", int'(bus.ready), 1);
      check("n255_no_wrap", int'(dec_a), 0);

      // N=20 with 3 Hold cycles and ignored Load pulses
      bus.load = 1'b1; bus.load_val = 8'd20;
      exp_q.push_back(cyc + 1 + 23);
      tick();
      bus.load = 1'b0;
      ticks(4);
      check("hold_pre", int'(dec_a), 16);
      bus.hold = 1'b1; bus.load = 1'b1; bus.load_val = 8'd5;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_frozen", int'(dec_a), 16);
      end
      bus.hold = 1'b0; bus.load = 1'b0;
      ticks(16);
      check("hold_ready_in_done", int'(bus.ready), 0);
      tick();
      check("hold_ready", int'(bus.ready), 1);

      // Clear at dec_a=5 beats a simultaneous Load
      bus.load = 1'b1; bus.load_val = 8'd20;
      tick();
      bus.load = 1'b0;
      ticks(15);
      check("clr_pre", int'(dec_a), 5);
      bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 8'd7;
      tick();
      check("clr_ready", int'(bus.ready), 1);
      check("clr_dec_a", int'(dec_a), 0);
      check("clr_busy", int'(bus.busy), 0);
      bus.clear = 1'b0; bus.load_val = 8'd20;
      exp_q.push_back(cyc + 1 + 20);
      tick();
      bus.load = 1'b0;
      check("clr_reload", int'(dec_a), 20);
      ticks(21);
      check("clr_after_ready", int'(bus.ready), 1);

      // Asynchronous reset mid-count
      bus.load = 1'b1; bus.load_val = 8'd5;
      tick();
      bus.load = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_dec_a", int'(dec_a), 0);
      check("arst_ready", int'(bus.ready), 1);
      check("arst_busy", int'(bus.busy), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // N=3: periodic with autoreload, otherwise one-shot
      bus.load = 1'b1; bus.load_val = 8'd3;
      exp_q.push_back(cyc + 1 + 3);
`ifdef COUNTDOWN_AUTORELOAD_EN
      exp_q.push_back(cyc + 1 + 7);
      exp_q.push_back(cyc + 1 + 11);
`endif
      tick();
      bus.load = 1'b0;
      ticks(5);
`ifdef COUNTDOWN_AUTORELOAD_EN
      check("auto_ready_low", int'(bus.ready), 0);
`else
      check("oneshot_ready", int'(bus.ready), 1);
`endif
      ticks(7);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("auto_clr_ready", int'(bus.ready), 1);
      ticks(8);
      check("auto_clr_idle", int'(bus.ready), 1);

      check("pending_done", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
